// File: rtl/fp_div_seq.sv
// Iterative binary32 divider, one restoring-division quotient bit per cycle.
// Subnormals flush to zero; valid/ready handshake on both sides, one op in flight.
module fp_div_seq #(
  parameter int          QBITS     = 27,
  parameter logic [31:0] NAN_CANON = 32'h7FC0_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fp_X,
  input  logic [31:0] fp_Y,
  input  logic [2:0]  r_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] fp_Z,
  output logic        ovrf,
  output logic        udrf
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DIVIDE     = 2'd1,
    NORM_ROUND = 2'd2,
    DONE       = 2'd3
  } state_t;

  // Rounding increment from lsb, guard and the OR of round/sticky; codes 101-111 fall to RNE.
  function automatic logic round_inc(input logic [2:0] rm, input logic sgn,
                                     input logic lsb, input logic g, input logic rs);
    logic inc;
    case (rm)
      3'b001:  inc = 1'b0;
      3'b010:  inc = sgn & (g | rs);
      3'b011:  inc = ~sgn & (g | rs);
      3'b100:  inc = g;
      default: inc = g & (rs | lsb);
    endcase
    return inc;
  endfunction

  function automatic logic [31:0] ovf_result(input logic [2:0] rm, input logic sgn);
    logic [31:0] res;
    case (rm)
      3'b001:  res = {sgn, 8'hFE, 23'h7F_FFFF};
      3'b010:  res = sgn ? {sgn, 8'hFF, 23'd0} : {sgn, 8'hFE, 23'h7F_FFFF};
      3'b011:  res = sgn ? {sgn, 8'hFE, 23'h7F_FFFF} : {sgn, 8'hFF, 23'd0};
      default: res = {sgn, 8'hFF, 23'd0};
    endcase
    return res;
  endfunction

  state_t             state_r, state_s;
  logic               in_ready_r, out_valid_r, ovrf_r, udrf_r;
  logic [31:0]        fp_z_r;
  logic               sign_r;
  logic [2:0]         rmode_r;
  logic signed [9:0]  exp_r;
  logic [23:0]        div_r;
  logic [24:0]        rem_r;
  logic [QBITS-1:0]   quo_r;
  logic [4:0]         cnt_r;

  logic               accept_s, special_s;
  logic [31:0]        special_z_s;
  logic               ge_s;
  logic [23:0]        rem_sub_s;
  logic               norm_s, guard_s, rnd_s, sticky_s, inc_s;
  logic [23:0]        mant_s;
  logic [24:0]        mant_rnd_s;
  logic [22:0]        frac_s;
  logic signed [9:0]  exp_n_s, exp_f_s;
  logic [31:0]        res_z_s;
  logic               res_ovrf_s, res_udrf_s;

  assign accept_s  = in_valid & in_ready_r;
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign fp_Z      = fp_z_r;
  assign ovrf      = ovrf_r;
  assign udrf      = udrf_r;

  // Special-operand decode on the live inputs, used only on the accept edge.
  always_comb begin
    logic x_zero, y_zero, x_inf, y_inf, x_nan, y_nan, sgn;
    x_zero      = (fp_X[30:23] == 8'd0);
    y_zero      = (fp_Y[30:23] == 8'd0);
    x_inf       = (fp_X[30:23] == 8'hFF) & (fp_X[22:0] == 23'd0);
    y_inf       = (fp_Y[30:23] == 8'hFF) & (fp_Y[22:0] == 23'd0);
    x_nan       = (fp_X[30:23] == 8'hFF) & (fp_X[22:0] != 23'd0);
    y_nan       = (fp_Y[30:23] == 8'hFF) & (fp_Y[22:0] != 23'd0);
    sgn         = fp_X[31] ^ fp_Y[31];
    special_s   = 1'b1;
    special_z_s = 32'd0;
    if (x_nan | y_nan | (x_zero & y_zero) | (x_inf & y_inf)) begin
      special_z_s = NAN_CANON;
    end else if (x_inf | y_zero) begin
      special_z_s = {sgn, 8'hFF, 23'd0};
    end else if (x_zero | y_inf) begin
      special_z_s = {sgn, 31'd0};
    end else begin
      special_s = 1'b0;
    end
  end

  // One restoring step: the remainder stays below twice the divisor, so 25 bits suffice.
  always_comb begin
    ge_s      = (rem_r >= {1'b0, div_r});
    rem_sub_s = ge_s ? 24'(rem_r - {1'b0, div_r}) : rem_r[23:0];
  end

  // Normalise, round and classify the finished quotient.
  always_comb begin
    norm_s     = quo_r[QBITS-1];
    mant_s     = norm_s ? quo_r[QBITS-1 -: 24] : quo_r[QBITS-2 -: 24];
    guard_s    = norm_s ? quo_r[QBITS-25] : quo_r[QBITS-26];
    rnd_s      = norm_s ? quo_r[QBITS-26] : quo_r[QBITS-27];
    sticky_s   = (norm_s & quo_r[0]) | (|rem_r);
    inc_s      = round_inc(rmode_r, sign_r, mant_s[0], guard_s, rnd_s | sticky_s);
    mant_rnd_s = {1'b0, mant_s} + {24'd0, inc_s};
    frac_s     = mant_rnd_s[24] ? mant_rnd_s[23:1] : mant_rnd_s[22:0];
    exp_n_s    = norm_s ? exp_r : exp_r - 10'sd1;
    exp_f_s    = mant_rnd_s[24] ? exp_n_s + 10'sd1 : exp_n_s;
    res_z_s    = {sign_r, exp_f_s[7:0], frac_s};
    res_ovrf_s = 1'b0;
    res_udrf_s = 1'b0;
    if (exp_n_s <= 10'sd0) begin
      res_z_s    = {sign_r, 31'd0};
      res_udrf_s = 1'b1;
    end else if (exp_f_s >= 10'sd255) begin
      res_z_s    = ovf_result(rmode_r, sign_r);
      res_ovrf_s = 1'b1;
    end else begin
      res_ovrf_s = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = special_s ? DONE : DIVIDE;
        end else begin
          state_s = IDLE;
        end
      end
      DIVIDE: begin
        if (cnt_r == 5'(QBITS - 1)) begin
          state_s = NORM_ROUND;
        end else begin
          state_s = DIVIDE;
        end
      end
      NORM_ROUND: state_s = DONE;
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register with handshake outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
    end
  end

  // Operand capture and the iterative divide datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_r  <= 1'b0;
      rmode_r <= 3'd0;
      exp_r   <= 10'sd0;
      div_r   <= 24'd0;
      rem_r   <= 25'd0;
      quo_r   <= '0;
      cnt_r   <= 5'd0;
    end else if (state_r == IDLE && accept_s) begin
      sign_r  <= fp_X[31] ^ fp_Y[31];
      rmode_r <= r_mode;
      exp_r   <= $signed({2'b00, fp_X[30:23]}) - $signed({2'b00, fp_Y[30:23]}) + 10'sd127;
      div_r   <= {1'b1, fp_Y[22:0]};
      rem_r   <= {2'b01, fp_X[22:0]};
      quo_r   <= '0;
      cnt_r   <= 5'd0;
    end else if (state_r == DIVIDE) begin
      rem_r   <= {rem_sub_s, 1'b0};
      quo_r   <= {quo_r[QBITS-2:0], ge_s};
      cnt_r   <= cnt_r + 5'd1;
    end
  end

  // Result registers: loaded for specials at accept or after rounding, otherwise held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fp_z_r <= 32'd0;
      ovrf_r <= 1'b0;
      udrf_r <= 1'b0;
    end else if (state_r == IDLE && accept_s && special_s) begin
      fp_z_r <= special_z_s;
      ovrf_r <= 1'b0;
      udrf_r <= 1'b0;
    end else if (state_r == NORM_ROUND) begin
      fp_z_r <= res_z_s;
      ovrf_r <= res_ovrf_s;
      udrf_r <= res_udrf_s;
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed self-checking bench for fp_div_seq: vector table plus hold,
// ignored-input and mid-divide reset sequences.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready;
  logic [31:0] fp_X, fp_Y;
  logic [2:0]  r_mode;
  logic        in_ready, out_valid, ovrf, udrf;
  logic [31:0] fp_Z;

  int n_tests = 0;
  int n_fail  = 0;

  // lat = rising edges after the accept edge until out_valid is seen
  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [2:0]  rm;
    logic [31:0] z;
    logic        ov;
    logic        ud;
    int          lat;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs[NV];

  fp_div_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .fp_X(fp_X), .fp_Y(fp_Y), .r_mode(r_mode), .out_valid(out_valid),
    .out_ready(out_ready), .fp_Z(fp_Z), .ovrf(ovrf), .udrf(udrf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Wait (bounded) for out_valid at negedges; returns edges counted after the accept edge.
  task automatic wait_valid(input string tag, output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, " out_valid seen"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    fp_X = v.x; fp_Y = v.y; r_mode = v.rm; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; fp_X = 32'h3F80_0000; fp_Y = 32'h3F80_0000; r_mode = 3'd1;
    wait_valid(tag, lat);
    check({tag, " latency"}, 32'(lat), 32'(v.lat));
    check({tag, " fp_Z"}, fp_Z, v.z);
    check({tag, " flags"}, {30'd0, ovrf, udrf}, {30'd0, v.ov, v.ud});
    @(posedge clk);
    @(negedge clk);
    check({tag, " released"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    vecs[0]  = '{32'h40C0_0000, 32'h4000_0000, 3'd0, 32'h4040_0000, 1'b0, 1'b0, 28};
    vecs[1]  = '{32'hC0C0_0000, 32'h4000_0000, 3'd0, 32'hC040_0000, 1'b0, 1'b0, 28};
    vecs[2]  = '{32'h3F80_0000, 32'h4040_0000, 3'd0, 32'h3EAA_AAAB, 1'b0, 1'b0, 28};
    vecs[3]  = '{32'h3F80_0000, 32'h4040_0000, 3'd1, 32'h3EAA_AAAA, 1'b0, 1'b0, 28};
    vecs[4]  = '{32'h3F80_0000, 32'h4040_0000, 3'd3, 32'h3EAA_AAAB, 1'b0, 1'b0, 28};
    vecs[5]  = '{32'h3F80_0000, 32'h4040_0000, 3'd2, 32'h3EAA_AAAA, 1'b0, 1'b0, 28};
    vecs[6]  = '{32'h3F80_0000, 32'h4040_0000, 3'd4, 32'h3EAA_AAAB, 1'b0, 1'b0, 28};
    vecs[7]  = '{32'h3F80_0000, 32'h4040_0000, 3'd7, 32'h3EAA_AAAB, 1'b0, 1'b0, 28};
    vecs[8]  = '{32'h3F80_0000, 32'h0000_0000, 3'd0, 32'h7F80_0000, 1'b0, 1'b0, 0};
    vecs[9]  = '{32'h0000_0000, 32'h0000_0000, 3'd0, 32'h7FC0_0000, 1'b0, 1'b0, 0};
    vecs[10] = '{32'h7FC0_0001, 32'h3F80_0000, 3'd0, 32'h7FC0_0000, 1'b0, 1'b0, 0};
    vecs[11] = '{32'h3F80_0000, 32'h7F80_0000, 3'd0, 32'h0000_0000, 1'b0, 1'b0, 0};
    vecs[12] = '{32'h0040_0000, 32'h3F80_0000, 3'd0, 32'h0000_0000, 1'b0, 1'b0, 0};
    vecs[13] = '{32'h7F00_0000, 32'h0080_0000, 3'd0, 32'h7F80_0000, 1'b1, 1'b0, 28};
    vecs[14] = '{32'h7F00_0000, 32'h0080_0000, 3'd1, 32'h7F7F_FFFF, 1'b1, 1'b0, 28};
    vecs[15] = '{32'h0080_0000, 32'h4000_0000, 3'd0, 32'h0000_0000, 1'b0, 1'b1, 28};
    vecs[16] = '{32'hFF00_0000, 32'h0080_0000, 3'd2, 32'hFF80_0000, 1'b1, 1'b0, 28};
    vecs[17] = '{32'hFF00_0000, 32'h0080_0000, 3'd3, 32'hFF7F_FFFF, 1'b1, 1'b0, 28};
    vecs[18] = '{32'h7F80_0000, 32'hFF80_0000, 3'd0, 32'h7FC0_0000, 1'b0, 1'b0, 0};
    vecs[19] = '{32'hC000_0000, 32'h7F80_0000, 3'd0, 32'h8000_0000, 1'b0, 1'b0, 0};
    vecs[20] = '{32'hFF80_0000, 32'h3F80_0000, 3'd0, 32'hFF80_0000, 1'b0, 1'b0, 0};
    vecs[21] = '{32'hBF80_0000, 32'h0000_0000, 3'd0, 32'hFF80_0000, 1'b0, 1'b0, 0};
    vecs[22] = '{32'hBF80_0000, 32'h4040_0000, 3'd2, 32'hBEAA_AAAB, 1'b0, 1'b0, 28};
    vecs[23] = '{32'hBF80_0000, 32'h4040_0000, 3'd3, 32'hBEAA_AAAA, 1'b0, 1'b0, 28};
    vecs[24] = '{32'h7F00_0000, 32'h0080_0000, 3'd3, 32'h7F80_0000, 1'b1, 1'b0, 28};
    vecs[25] = '{32'h7F00_0000, 32'h0080_0000, 3'd2, 32'h7F7F_FFFF, 1'b1, 1'b0, 28};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    fp_X = 32'd0; fp_Y = 32'd0; r_mode = 3'd0;
    #12;
    check("reset ctl", {30'd0, out_valid, in_ready}, 32'd1);
    check("reset fp_Z", fp_Z, 32'd0);
    check("reset flags", {30'd0, ovrf, udrf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Consumer stalls for 10 cycles; a stray in_valid pulse must be ignored.
    @(negedge clk);
    out_ready = 1'b0;
    fp_X = 32'h40C0_0000; fp_Y = 32'h4000_0000; r_mode = 3'd0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid("hold", lat);
    check("hold latency", 32'(lat), 32'd28);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("hold%0d fp_Z", c), fp_Z, 32'h4040_0000);
      check($sformatf("hold%0d ctl", c), {28'd0, out_valid, in_ready, ovrf, udrf}, 32'h8);
      if (c == 3) begin
        fp_X = 32'h3F80_0000; fp_Y = 32'h0000_0000; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("hold release ctl", {30'd0, out_valid, in_ready}, 32'd1);
    check("hold retained fp_Z", fp_Z, 32'h4040_0000);

    // Reset during DIVIDE cycle 12 discards the operation.
    @(negedge clk);
    fp_X = 32'h3F80_0000; fp_Y = 32'h4040_0000; r_mode = 3'd0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("divide busy", {31'd0, in_ready}, 32'd0);
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset ctl", {30'd0, out_valid, in_ready}, 32'd1);
    check("midreset fp_Z", fp_Z, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[0], "after reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_div_seq.md
Name: fp_div_seq

Overview:
- Iterative single-precision (IEEE-754 binary32) divider, fp_Z = fp_X / fp_Y. It is the inverse-operation companion to the FPU multiplier.
- It sits beside the multiplier in the ALU and uses the same operand/result/flag naming: fp_X, fp_Y, fp_Z, r_mode, ovrf, udrf.
- It produces one quotient bit per cycle with restoring division.
- It uses a valid/ready handshake on input and output. Subnormal handling matches the multiplier: flush-to-zero.

Parameters:
- QBITS, 27, number of quotient bits produced: 24 significand + guard + round + 1 normalisation bit. Sticky comes from the remainder.
- NAN_CANON, 32'h7FC00000, canonical quiet NaN returned for every invalid/NaN case.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  divider can accept an operation.
- fp_X  in  32  dividend.
- fp_Y  in  32  divisor.
- r_mode  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 treated as RNE.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- fp_Z  out  32  quotient.
- ovrf  out  1  overflow flag for this result.
- udrf  out  1  underflow flag for this result.

Behaviour:
- Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, fp_Z=0, ovrf=0, udrf=0, counter and datapath registers cleared. Any in-flight operation is discarded; no partial result appears.
- States are IDLE, DIVIDE, NORM_ROUND, DONE.
- in_ready=1 only in IDLE. Accept occurs on the edge where in_valid&in_ready. fp_X, fp_Y and r_mode are captured there; later input changes are ignored.
- Special cases are decoded at accept and go IDLE->DONE directly, so out_valid rises the cycle after accept. Exponent 0 is treated as zero (subnormal flush, udrf=0 for an input flush).
  - Either operand NaN, 0/0, or inf/inf: fp_Z=NAN_CANON.
  - inf/finite, or nonzero-finite/0: signed inf, ovrf=0.
  - 0/nonzero, or finite/inf: signed zero.
  - Sign is always sX^sY, except for NaN.
- Normal path: IDLE->DIVIDE at accept, counter=0.
  - Each DIVIDE cycle: remainder compared with divisor, one quotient bit shifted in, counter++.
  - After QBITS cycles: DIVIDE->NORM_ROUND.
  - NORM_ROUND->DONE, with fp_Z/ovrf/udrf registered.
  - out_valid rises exactly 28 cycles after accept.
- Arithmetic:
  - mX, mY are 24-bit with hidden 1. Biased exponent e = eX - eY + 127, computed as signed 10-bit.
  - If quotient MSB=0: shift left 1 and e -= 1.
  - Sticky = OR of final remainder.
  - Round using guard/round/sticky per r_mode. Mantissa carry-out increments e.
- Overflow (after rounding, e>=255): ovrf=1. Result:
  - RNE or RMM: signed inf.
  - RTZ: signed max finite (7F7FFFFF / FF7FFFFF).
  - RDN: +max if positive, -inf if negative.
  - RUP: +inf if positive, -max if negative.
- Underflow (e<=0 before rounding): fp_Z = signed zero, udrf=1. Flush-to-zero; no subnormal output.
- ovrf and udrf are never both 1.
- DONE: fp_Z/ovrf/udrf held stable while out_valid=1 and out_ready=0. On out_valid&out_ready: DONE->IDLE, out_valid=0 next cycle, fp_Z retains its last value.
- No overlap: the next operation is accepted only after the result has been consumed. in_valid in non-IDLE states is ignored.
- out_ready=1 constantly gives a throughput of one operation per 30 cycles on the normal path (accept, 28 cycles, handshake, IDLE).

Test Plan:
- 40C00000 / 40000000 (6.0/2.0), RNE, out_ready=1 -> fp_Z=40400000, ovrf=0, udrf=0, out_valid exactly 28 cycles after accept. C0C00000/40000000 -> C0400000.
- 3F800000 / 40400000 (1/3) -> RNE: 3EAAAAAB; RTZ: 3EAAAAAA; RUP: 3EAAAAAB; RDN: 3EAAAAAA.
- Specials, each with out_valid 1 cycle after accept:
  - 3F800000/00000000 -> 7F800000.
  - 00000000/00000000 -> 7FC00000.
  - 7FC00001/3F800000 -> 7FC00000.
  - 3F800000/7F800000 -> 00000000.
  - 00400000/3F800000 -> 00000000 with udrf=0.
- 7F000000 / 00800000 -> RNE: 7F800000 ovrf=1; RTZ: 7F7FFFFF ovrf=1. 00800000 / 40000000 -> 00000000 udrf=1.
- Hold out_ready=0 for 10 cycles after out_valid -> fp_Z/flags stable, in_ready=0, and a new in_valid pulse is ignored. Raise out_ready -> IDLE next cycle and in_ready=1.
- Assert rst_n=0 at DIVIDE cycle 12 -> out_valid=0 and in_ready=1 immediately. The next operation 40C00000/40000000 completes correctly with 40400000.
